// File: rtl/snn_frame_ctrl_if.sv
// snn_frame_ctrl_if: bundles the UART, input-RAM, core and status signals of the frame sequencer.
// master = sequencer side, slave = surrounding UART / RAM / snn_core side.
interface snn_frame_ctrl_if;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       clr_rx_rdy;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic [9:0] core_addr;
    logic       core_start;
    logic       core_done;
    logic [3:0] core_digit;
    logic [7:0] tx_data;
    logic       trmt;
    logic       tx_done;
    logic       busy;
    logic [3:0] result;
    logic       result_vld;

    modport master (
        input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
        output clr_rx_rdy, ram_addr, ram_data, ram_we, core_start,
        output tx_data, trmt, busy, result, result_vld
    );

    modport slave (
        output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
        input  clr_rx_rdy, ram_addr, ram_data, ram_we, core_start,
        input  tx_data, trmt, busy, result, result_vld
    );
endinterface

// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: unpacks UART pixel bytes into the 1-bit input RAM, runs snn_core,
// latches the winning digit and sends it as ASCII. Ports: clk, rst_n, bus (master modport).
module snn_frame_ctrl #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter logic [7:0]  ASCII_BASE = 8'h30
) (
    input  logic             clk,
    input  logic             rst_n,
    snn_frame_ctrl_if.master bus
);
    localparam int unsigned NUM_BYTES = NUM_PIXELS / 8;
    localparam logic [9:0]  LAST_PIX  = 10'(NUM_BYTES * 8 - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, START, RUN, TX, WAIT_TX
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] pix_cnt;
    logic [7:0] shreg;
    logic [3:0] result;
    logic       result_vld;
    logic [7:0] tx_data;
    logic       accept;
    logic       last_bit;

    logic       clr_rx_rdy;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic       core_start;
    logic       trmt;

    assign accept   = (state == IDLE || state == LOAD) && bus.rx_rdy;
    // pix_cnt low bits double as the bit index within the current byte
    assign last_bit = (pix_cnt[2:0] == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, LOAD: if (bus.rx_rdy) state_nxt = WRITE;
            WRITE:      if (last_bit) begin
                            state_nxt = (pix_cnt == LAST_PIX) ? START : LOAD;
                        end
            START:      state_nxt = RUN;
            RUN:        if (bus.core_done) state_nxt = TX;
            TX:         state_nxt = WAIT_TX;
            WAIT_TX:    if (bus.tx_done) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clr_rx_rdy = 1'b0;
        ram_we     = 1'b0;
        ram_data   = 1'b0;
        ram_addr   = pix_cnt;
        core_start = 1'b0;
        trmt       = 1'b0;
        unique case (state)
            IDLE, LOAD: clr_rx_rdy = bus.rx_rdy;
            WRITE: begin
                ram_we   = 1'b1;
                ram_data = shreg[0];
            end
            START: begin
                core_start = 1'b1;
                ram_addr   = bus.core_addr;
            end
            RUN:     ram_addr = bus.core_addr;
            TX:      trmt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            shreg      <= '0;
            result     <= '0;
            result_vld <= 1'b0;
            tx_data    <= '0;
        end else begin
            if (accept) begin
                shreg <= bus.rx_data;
                // a new frame invalidates the previous answer
                if (state == IDLE) result_vld <= 1'b0;
            end
            if (state == WRITE) begin
                shreg   <= {1'b0, shreg[7:1]};
                pix_cnt <= pix_cnt + 10'd1;
            end
            if (state == START) pix_cnt <= '0;
            if (state == RUN && bus.core_done) begin
                result     <= bus.core_digit;
                result_vld <= 1'b1;
                tx_data    <= ASCII_BASE + {4'd0, bus.core_digit};
            end
        end
    end

    assign bus.clr_rx_rdy = clr_rx_rdy;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_data   = ram_data;
    assign bus.ram_we     = ram_we;
    assign bus.core_start = core_start;
    assign bus.trmt       = trmt;
    assign bus.tx_data    = tx_data;
    assign bus.result     = result;
    assign bus.result_vld = result_vld;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_snn_frame_ctrl.sv
// tb_snn_frame_ctrl: random UART/core/TX environment around snn_frame_ctrl,
// checked every cycle against a frame-level reference model plus literal pins.
module tb_snn_frame_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    snn_frame_ctrl_if bus ();

    snn_frame_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] a;
        logic       d;
    } wr_t;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // reference model
    wr_t        wr_q[$];
    int         bytes_acc = 0;
    bit         in_proc   = 0;
    bit         running   = 0;
    bit         waiting   = 0;
    bit         exp_start = 0;
    bit         exp_trmt  = 0;
    logic [3:0] m_res     = '0;
    bit         m_vld     = 0;
    logic [7:0] m_tx      = '0;

    // byte source, reset requests, forced digit
    logic [7:0] src[0:1023];
    int         src_n       = 0;
    int         src_i       = 0;
    int         rst_req     = 0;
    int         rst_seen    = 0;
    int         rst_left    = 3;
    int         force_digit = -1;

    // environment state and next-cycle drive values
    int         gap     = 0;
    int         run_cnt = 0;
    int         tx_cnt  = 0;
    logic       n_rx_rdy  = 1'b0;
    logic [7:0] n_rx_data = '0;
    logic [9:0] n_caddr   = '0;
    logic       n_done    = 1'b0;
    logic [3:0] n_digit   = '0;
    logic       n_tdone   = 1'b0;

    // per-frame observations
    int         cyc = 0;
    int         frames = 0;
    int         c_wr, c_one, c_max, c_clr, c_start, c_gap, c_first;
    int         last_wr_cyc;
    logic [7:0] c_first8;
    logic [7:0] c_tx;
    int         f_wr[8], f_one[8], f_max[8], f_clr[8];
    int         f_start[8], f_gap[8], f_first[8];
    logic [7:0] f_first8[8], f_tx[8];
    logic [3:0] f_res[8];
    logic       f_vld[8];

    task automatic clr_stats();
        c_wr = 0; c_one = 0; c_max = -1; c_clr = 0;
        c_start = 0; c_gap = -1; c_first = -1;
        last_wr_cyc = -100; c_first8 = '0; c_tx = '0;
    endtask

    initial clr_stats();

    always begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            chk("rst_clr_rx_rdy", bus.clr_rx_rdy, 0);
            chk("rst_ram_we", bus.ram_we, 0);
            chk("rst_ram_data", bus.ram_data, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_core_start", bus.core_start, 0);
            chk("rst_trmt", bus.trmt, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_result_vld", bus.result_vld, 0);
            chk("rst_tx_data", bus.tx_data, 0);
            wr_q.delete();
            bytes_acc = 0; in_proc = 0; running = 0; waiting = 0;
            exp_start = 0; exp_trmt = 0;
            m_res = '0; m_vld = 0; m_tx = '0;
            gap = 0; run_cnt = 0; tx_cnt = 0;
            n_rx_rdy = 0; n_done = 0; n_tdone = 0; n_caddr = '0;
            clr_stats();
        end else begin
            bit exp_we, exp_clr, nstart, ntrmt;
            exp_we  = (wr_q.size() > 0);
            exp_clr = bus.rx_rdy && !exp_we && !in_proc;

            chk("clr_rx_rdy", bus.clr_rx_rdy, exp_clr);
            chk("ram_we", bus.ram_we, exp_we);
            if (exp_we) begin
                chk("ram_addr_wr", bus.ram_addr, wr_q[0].a);
                chk("ram_data", bus.ram_data, wr_q[0].d);
            end
            chk("core_start", bus.core_start, exp_start);
            if (exp_start || running) begin
                chk("ram_addr_core", bus.ram_addr, bus.core_addr);
            end
            chk("trmt", bus.trmt, exp_trmt);
            chk("busy", bus.busy, (bytes_acc != 0) || in_proc);
            chk("result", bus.result, m_res);
            chk("result_vld", bus.result_vld, m_vld);
            chk("tx_data", bus.tx_data, m_tx);

            // observations for the literal frame checks
            if (bus.clr_rx_rdy) c_clr++;
            if (bus.ram_we) begin
                if (c_wr == 0) c_first = int'(bus.ram_addr);
                c_wr++;
                if (bus.ram_data) c_one++;
                if (int'(bus.ram_addr) > c_max) c_max = int'(bus.ram_addr);
                if (bus.ram_addr < 10'd8) c_first8[bus.ram_addr[2:0]] = bus.ram_data;
                if (bus.ram_addr == 10'd783) last_wr_cyc = cyc;
            end
            if (bus.core_start) begin
                c_start++;
                c_gap = cyc - last_wr_cyc;
            end
            if (bus.trmt) c_tx = bus.tx_data;

            // model advance to the next cycle
            nstart = 0;
            ntrmt  = 0;
            if (exp_clr) begin
                if (bytes_acc == 0) m_vld = 0;
                for (int i = 0; i < 8; i++) begin
                    wr_q.push_back('{a: 10'(bytes_acc * 8 + i), d: bus.rx_data[i]});
                end
                bytes_acc++;
            end
            if (exp_we) begin
                void'(wr_q.pop_front());
                if (wr_q.size() == 0 && bytes_acc == 98) begin
                    nstart  = 1;
                    in_proc = 1;
                end
            end
            if (running && bus.core_done) begin
                m_res   = bus.core_digit;
                m_vld   = 1;
                m_tx    = 8'h30 + {4'h0, bus.core_digit};
                running = 0;
                ntrmt   = 1;
            end
            if (exp_start) running = 1;
            if (waiting && bus.tx_done) begin
                waiting   = 0;
                in_proc   = 0;
                bytes_acc = 0;
                if (frames < 8) begin
                    f_wr[frames]     = c_wr;
                    f_one[frames]    = c_one;
                    f_max[frames]    = c_max;
                    f_clr[frames]    = c_clr;
                    f_start[frames]  = c_start;
                    f_gap[frames]    = c_gap;
                    f_first[frames]  = c_first;
                    f_first8[frames] = c_first8;
                    f_tx[frames]     = c_tx;
                    f_res[frames]    = bus.result;
                    f_vld[frames]    = bus.result_vld;
                end
                frames++;
                clr_stats();
            end
            if (exp_trmt) waiting = 1;
            exp_start = nstart;
            exp_trmt  = ntrmt;

            // UART RX: level held until acknowledged
            if (bus.rx_rdy && bus.clr_rx_rdy) begin
                n_rx_rdy = 0;
                gap = $urandom_range(0, 3);
            end else if (!bus.rx_rdy) begin
                if (gap > 0) begin
                    gap--;
                end else if (src_i < src_n) begin
                    n_rx_rdy  = 1;
                    n_rx_data = src[src_i];
                    src_i++;
                end
            end

            // core: address sweep, done after a random run length
            if (bus.core_start || bus.core_addr >= 10'd783) n_caddr = '0;
            else n_caddr = bus.core_addr + 10'd1;
            n_done  = 0;
            n_digit = 4'($urandom);
            if (bus.core_start) begin
                run_cnt = $urandom_range(3, 900);
            end else if (run_cnt > 0) begin
                run_cnt--;
                if (run_cnt == 0) begin
                    n_done  = 1;
                    n_digit = (force_digit >= 0) ? 4'(force_digit)
                                                 : 4'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 63) == 0) begin
                n_done = 1;
            end

            // UART TX: random transmit time, occasional stray tx_done
            n_tdone = 0;
            if (bus.trmt) begin
                tx_cnt = $urandom_range(1, 20);
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) n_tdone = 1;
            end else if ($urandom_range(0, 63) == 0) begin
                n_tdone = 1;
            end
        end

        @(posedge clk);
        #1;
        if (rst_left == 0 && rst_seen != rst_req) begin
            rst_seen = rst_req;
            rst_left = 3;
        end
        if (rst_left > 0) begin
            rst_left--;
            rst_n    = 1'b0;
            n_rx_rdy = 1'b0;
        end else begin
            rst_n = 1'b1;
        end
        bus.rx_rdy     = n_rx_rdy;
        bus.rx_data    = n_rx_data;
        bus.core_addr  = n_caddr;
        bus.core_done  = n_done;
        bus.core_digit = n_digit;
        bus.tx_done    = n_tdone;
    end

    task automatic push(input logic [7:0] b);
        src[src_n] = b;
        src_n++;
    endtask

    task automatic wait_frames(input int k);
        int budget;
        budget = 9000 * (k - frames);
        for (int i = 0; i < budget && frames < k; i++) @(negedge clk);
        if (frames < k) chk("frame_timeout", frames, k);
    endtask

    initial begin
        repeat (6) @(negedge clk);

        force_digit = 7;
        for (int i = 0; i < 98; i++) push(8'hFF);
        push(8'hA5);
        for (int i = 0; i < 97; i++) push(8'($urandom));
        wait_frames(1);
        chk("f0_writes", f_wr[0], 784);
        chk("f0_ones", f_one[0], 784);
        chk("f0_max_addr", f_max[0], 783);
        chk("f0_clr_pulses", f_clr[0], 98);
        chk("f0_starts", f_start[0], 1);
        chk("f0_start_gap", f_gap[0], 1);
        chk("f0_tx_byte", f_tx[0], 8'h37);
        chk("f0_result", f_res[0], 7);
        chk("f0_result_vld", f_vld[0], 1);

        force_digit = -1;
        for (int i = 0; i < 196; i++) push(8'($urandom));
        wait_frames(4);
        chk("f1_first8", f_first8[1], 8'hA5);
        chk("f1_first_addr", f_first[1], 0);
        for (int f = 1; f < 4; f++) begin
            chk("fx_writes", f_wr[f], 784);
            chk("fx_clr_pulses", f_clr[f], 98);
            chk("fx_starts", f_start[f], 1);
            chk("fx_start_gap", f_gap[f], 1);
        end

        for (int i = 0; i < 40; i++) push(8'($urandom));
        for (int i = 0; i < 2000 && c_clr < 40; i++) @(negedge clk);
        chk("partial_clr", c_clr, 40);
        repeat (10) @(negedge clk);
        rst_req++;
        repeat (2) @(negedge clk);
        #2;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_vld", bus.result_vld, 0);
        chk("midrst_tx_data", bus.tx_data, 0);
        chk("midrst_ram_we", bus.ram_we, 0);
        repeat (4) @(negedge clk);

        force_digit = 3;
        for (int i = 0; i < 98; i++) push(8'($urandom));
        wait_frames(5);
        chk("f4_first_addr", f_first[4], 0);
        chk("f4_writes", f_wr[4], 784);
        chk("f4_max_addr", f_max[4], 783);
        chk("f4_clr_pulses", f_clr[4], 98);
        chk("f4_tx_byte", f_tx[4], 8'h33);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
